// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_MASTERS requesters.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT_RESP -> IDLE.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req_valid,
  output logic [NUM_MASTERS-1:0]            req_ready,
  input  logic [NUM_MASTERS-1:0]            req_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_MASTERS-1:0]            resp_valid,
  output logic [DATA_W-1:0]                 resp_rdata,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic [DATA_W/8-1:0]               mem_wstrb,
  input  logic                              mem_resp_valid,
  input  logic [DATA_W-1:0]                 mem_resp_rdata,
  output logic                              busy,
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_id
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int SW = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [SW-1:0]          mem_wstrb_q, mem_wstrb_d;
  logic [NUM_MASTERS-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]      resp_rdata_q, resp_rdata_d;

  logic          grant_found;
  logic [GW-1:0] grant_idx;
  logic [GW:0]   cand;
  logic          handshake;

  // Search upward from last_grant+1, wrapping at NUM_MASTERS; first hit wins.
  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = {1'b0, last_grant_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_MASTERS)) begin
        cand = cand - (GW+1)'(NUM_MASTERS);
      end
      if (!grant_found && req_valid[cand[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[GW-1:0];
      end
    end
  end

  assign handshake = (state_q == S_IDLE) && grant_found;
  assign req_ready = handshake ? (NUM_MASTERS'(1) << grant_idx) : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == grant_idx) begin
              mem_we_d    = req_we[i];
              mem_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              mem_wdata_d = req_wdata[i*DATA_W +: DATA_W];
              mem_wstrb_d = req_wstrb[i*SW +: SW];
            end
          end
          grant_id_d = grant_idx;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Fairness pointer only advances once the owner's transaction completes.
        if (mem_resp_valid) begin
          resp_rdata_d = mem_resp_rdata;
          resp_valid_d = NUM_MASTERS'(1) << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_MASTERS - 1);
      grant_id_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == S_ISSUE);
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = grant_id_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (4 masters): directed scenarios followed by
// randomized transactions checked against a round-robin reference model.
module tb_mem_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     req_valid;
  logic [NM-1:0]     req_ready;
  logic [NM-1:0]     req_we;
  logic [NM*AW-1:0]  req_addr;
  logic [NM*DW-1:0]  req_wdata;
  logic [NM*SW-1:0]  req_wstrb;
  logic [NM-1:0]     resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [SW-1:0]     mem_wstrb;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_rdata;
  logic              busy;
  logic [1:0]        grant_id;

  mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wstrb      (req_wstrb),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: who was served last, plus what each master is offering.
  int          model_last;
  logic        pay_we    [NM];
  logic [31:0] pay_addr  [NM];
  logic [31:0] pay_wdata [NM];
  logic [3:0]  pay_wstrb [NM];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_payload(input int m, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    pay_we[m]    = we;
    pay_addr[m]  = a;
    pay_wdata[m] = d;
    pay_wstrb[m] = s;
    req_we[m]              = we;
    req_addr[m*AW +: AW]   = a;
    req_wdata[m*DW +: DW]  = d;
    req_wstrb[m*SW +: SW]  = s;
  endtask

  function automatic int model_pick(input logic [NM-1:0] v);
    for (int k = 1; k <= NM; k++) begin
      int idx = (model_last + k) % NM;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One full transaction: offer mask, stall accept for rdly cycles, respond sdly
  // cycles after accept. Called with the arbiter idle, just after an edge.
  task automatic run_txn(input logic [NM-1:0] mask, input int rdly, input int sdly,
                         input logic [31:0] rdata, output int got);
    int            exp_m;
    logic [NM-1:0] oh;
    exp_m = model_pick(mask);
    oh = '0;
    oh[exp_m] = 1'b1;
    req_valid = mask;
    #1;
    check("req_ready_grant", req_ready, oh);
    tick();
    req_valid = mask & ~oh;
    #1;
    got = int'(grant_id);
    check("grant_id", grant_id, exp_m);
    check("issue_mem_req_valid", mem_req_valid, 1);
    check("issue_mem_we", mem_we, pay_we[exp_m]);
    check("issue_mem_addr", mem_addr, pay_addr[exp_m]);
    check("issue_mem_wdata", mem_wdata, pay_wdata[exp_m]);
    check("issue_mem_wstrb", mem_wstrb, pay_wstrb[exp_m]);
    check("issue_busy", busy, 1);
    check("issue_req_ready", req_ready, 0);
    check("resp_pulse_one_cycle", resp_valid, 0);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check("bp_mem_req_valid", mem_req_valid, 1);
      check("bp_mem_addr", mem_addr, pay_addr[exp_m]);
      check("bp_mem_wdata", mem_wdata, pay_wdata[exp_m]);
      check("bp_mem_wstrb", mem_wstrb, pay_wstrb[exp_m]);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("wait_mem_req_valid", mem_req_valid, 0);
    check("wait_busy", busy, 1);
    check("wait_req_ready", req_ready, 0);
    for (int i = 0; i < sdly; i++) begin
      tick();
      check("wait_no_resp", resp_valid, 0);
      check("wait_busy_hold", busy, 1);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    check("resp_valid", resp_valid, oh);
    if (!pay_we[exp_m]) check("resp_rdata", resp_rdata, rdata);
    check("resp_busy", busy, 0);
    model_last = exp_m;
    req_valid = '0;
  endtask

  initial begin
    int got;
    rst            = 1'b1;
    req_valid      = '0;
    req_we         = '0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wstrb      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    for (int m = 0; m < NM; m++) set_payload(m, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    rst = 1'b0;
    model_last = NM - 1;
    check_reset_outputs("por");

    // Single read from master 1, zero-wait memory.
    set_payload(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    run_txn(4'b0010, 0, 0, 32'hDEAD_BEEF, got);

    // Write with partial strobes from master 0.
    set_payload(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    run_txn(4'b0001, 0, 0, 32'hCAFE_F00D, got);

    // Stray response while idle must be ignored.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hBAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_resp_valid", resp_valid, 0);
    check("stray_busy", busy, 0);
    check("stray_mem_req_valid", mem_req_valid, 0);
    tick();
    check("stray_resp_valid_2", resp_valid, 0);

    // Back-pressure: five cycles of mem_req_ready low, then a slow response.
    set_payload(2, 1'b1, 32'hA5A5_0040, 32'h0F0F_F0F0, 4'b1010);
    run_txn(4'b0100, 5, 2, 32'h1111_2222, got);

    // Reset in the middle of WAIT_RESP abandons the transaction.
    set_payload(3, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_last = NM - 1;
    check_reset_outputs("mid_rst");
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5555_AAAA;
    tick();
    mem_resp_valid = 1'b0;
    check("post_rst_no_resp", resp_valid, 0);
    check("post_rst_busy", busy, 0);

    // Fairness: all masters requesting continuously.
    for (int m = 0; m < NM; m++) set_payload(m, 1'($urandom), $urandom, $urandom, 4'($urandom));
    for (int i = 0; i < 8; i++) begin
      run_txn(4'hF, 0, 0, $urandom, got);
      check("rr_order", got, i % NM);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 24; i++) begin
      for (int m = 0; m < NM; m++) set_payload(m, 1'($urandom), $urandom, $urandom, 4'($urandom));
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one memory port between `NUM_MASTERS` requesters, such as the instruction and data ports of several cores. It sits between the per-core memory interfaces and a single imem/dmem or bus port. Exactly one transaction is outstanding at a time. Each granted request is registered, issued downstream with a valid/ready handshake, and its response is routed back to the owning master.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesters, legal range 2..4.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NUM_MASTERS: request valid, one bit per master.
- `req_ready`  out  NUM_MASTERS: request accepted, one bit per master.
- `req_we`  in  NUM_MASTERS: 1 = write, 0 = read.
- `req_addr`  in  NUM_MASTERS*ADDR_W: flattened; master i uses bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_MASTERS*DATA_W: flattened write data.
- `req_wstrb`  in  NUM_MASTERS*DATA_W/8: flattened byte strobes.
- `resp_valid`  out  NUM_MASTERS: one-cycle response pulse to the owning master.
- `resp_rdata`  out  DATA_W: read data, shared by all masters; qualified by `resp_valid`.
- `mem_req_valid`  out  1: downstream request valid.
- `mem_req_ready`  in  1: downstream accepts the request.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out: registered copy of the granted request.
- `mem_resp_valid`  in  1: downstream response (read data, or write acknowledge).
- `mem_resp_rdata`  in  DATA_W: downstream read data.
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  clog2(NUM_MASTERS): index of the current or last owner.

## Operation
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - Grant goes to the first master with `req_valid` set, searching upward from `last_grant+1` modulo `NUM_MASTERS`.
  - `req_ready[grant]=1` combinationally; all other `req_ready` bits are 0.
  - On the handshake, latch we/addr/wdata/wstrb into the `mem_*` registers, record the owner in `grant_id`, and go to ISSUE.
  - If no request is valid, stay in IDLE and keep `last_grant` unchanged.
- ISSUE:
  - `mem_req_valid=1`, and the `mem_*` outputs are held stable.
  - On `mem_req_ready=1`, go to WAIT_RESP.
- WAIT_RESP:
  - `mem_req_valid=0`.
  - On `mem_resp_valid=1`: register `mem_resp_rdata` into `resp_rdata`, set `resp_valid[owner]=1` for the next cycle only, set `last_grant=owner`, and go to IDLE.
- Writes also complete with a `resp_valid` pulse; `resp_rdata` is then don't-care.
- `mem_resp_valid` is ignored in IDLE and ISSUE. It arrives in the same cycle as the `mem_req_ready` handshake is not allowed: the downstream takes at least one cycle.
- `req_ready` is 0 in ISSUE and WAIT_RESP. Masters hold `req_valid` and their payload until `req_ready`. A request withdrawn before grant is dropped silently.
- Reset (`rst=1` at a rising edge):
  - state=IDLE, `last_grant=NUM_MASTERS-1`, so master 0 has first priority.
  - `grant_id=0`, `mem_req_valid=0`, `mem_*` registers=0, `resp_valid=0`, `resp_rdata=0`, `busy=0`.
  - A reset mid-transaction abandons the transaction; no response is delivered.

## Timing
- Request handshake in cycle T (IDLE): `mem_req_valid` rises at T+1.
- With `mem_req_ready=1` at T+1 and `mem_resp_valid=1` at T+2: `resp_valid` pulses at T+3, and the arbiter is back in IDLE at T+3, able to grant again in that cycle.
- Minimum turnaround is 3 cycles per transaction. Each extra cycle of `mem_req_ready` low or response delay adds one cycle.
- `req_ready` and the grant are combinational from `req_valid` and state. All other outputs are registered.
- Fairness: with all masters requesting continuously, each master is granted once per `NUM_MASTERS` transactions.

## Test plan
- **Reset values:** assert `rst` for 2 cycles mid-WAIT_RESP, then release. Expect every output 0, no `resp_valid`, and a first grant to master 0 when all masters request.
- **Single read, zero-wait memory:** master 1 reads 0x0000_0010; memory returns 0xDEAD_BEEF one cycle after accept. Expect `resp_valid[1]` exactly 3 cycles after the handshake, with `resp_rdata=0xDEAD_BEEF`.
- **Round-robin fairness:** `NUM_MASTERS=4`, all masters requesting continuously for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3.
- **Back-pressure:** hold `mem_req_ready` low for 5 cycles. Expect `mem_req_valid` held and `mem_addr`/`mem_wdata`/`mem_wstrb` stable throughout, `req_ready` all 0, and `busy=1`.
- **Write with strobes:** master 0 writes 0x1234_5678 with strobe 4'b0011. Expect `mem_we=1`, `mem_wstrb=0011`, and a `resp_valid[0]` pulse on the acknowledge.
- **Stray response:** pulse `mem_resp_valid` in IDLE. Expect no `resp_valid` and the state to remain IDLE.
